iteration_s_16: RTL and testbench



---
 rtl/maltsev_pkg.sv | 17 +
 rtl/iteration_s_16.sv | 127 ++++++++++++
 tb/tb_iteration_s_16.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/maltsev_pkg.sv
// rtl/maltsev_pkg.sv - shared types and defaults for the successor/iteration blocks
package maltsev_pkg;

  // Default operand/result width shared with the successor stage.
  localparam int BW_DEFAULT = 16;

  // Sequencer states for the iterated-successor loop.
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ISSUE     = 3'd1,
    WAIT_ACK  = 3'd2,
    WAIT_DONE = 3'd3,
    GAP       = 3'd4,
    FINISH    = 3'd5
  } state_e;

endpackage

// File: rtl/iteration_s_16.sv
// rtl/iteration_s_16.sv - computes RES = X + N by driving a successor stage N times
module iteration_s_16
  import maltsev_pkg::*;
#(
  parameter int BW = BW_DEFAULT
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          ST,
  output logic          RD,
  input  logic [BW-1:0] X,
  input  logic [BW-1:0] N,
  output logic [BW-1:0] RES,
  output logic          S_ST,
  output logic [BW-1:0] S_IN,
  input  logic          S_RD,
  input  logic [BW-1:0] S_RES
);

  state_e        state_q, state_d;
  logic          stold_q;
  logic [BW-1:0] acc_q, acc_d;
  logic [BW-1:0] cnt_q, cnt_d;
  logic          rd_q, rd_d;
  logic [BW-1:0] res_q, res_d;
  logic          s_st_q, s_st_d;
  logic [BW-1:0] s_in_q, s_in_d;
  logic          start;

  // A start is a fresh ST rising edge seen while idle; edges while busy are dropped.
  assign start = ST && !stold_q && rd_q && (state_q == IDLE);

  // Next-state and registered-output logic. S_ST/S_IN are computed here one
  // cycle ahead so that they are high for exactly ISSUE, WAIT_ACK and WAIT_DONE.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    rd_d    = rd_q;
    res_d   = res_q;
    s_st_d  = s_st_q;
    s_in_d  = s_in_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          acc_d = X;
          cnt_d = N;
          rd_d  = 1'b0;
          if (N == '0) begin
            // N=0 skips the child entirely; result is the operand itself.
            state_d = FINISH;
          end else begin
            state_d = ISSUE;
            s_st_d  = 1'b1;
            s_in_d  = X;
          end
        end
      end
      FINISH: begin
        res_d   = acc_q;
        rd_d    = 1'b1;
        state_d = IDLE;
      end
      ISSUE: begin
        state_d = WAIT_ACK;
      end
      WAIT_ACK: begin
        // Child has accepted once it drops its ready flag.
        if (!S_RD) begin
          state_d = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        if (S_RD) begin
          s_st_d = 1'b0;
          if (cnt_q == BW'(1)) begin
            res_d   = S_RES;
            rd_d    = 1'b1;
            state_d = IDLE;
          end else begin
            acc_d   = S_RES;
            cnt_d   = cnt_q - BW'(1);
            state_d = GAP;
          end
        end
      end
      GAP: begin
        // One low cycle on S_ST has elapsed, so the child will see a new edge.
        state_d = ISSUE;
        s_st_d  = 1'b1;
        s_in_d  = acc_q;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any run and clears the result.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      stold_q <= 1'b0;
      acc_q   <= '0;
      cnt_q   <= '0;
      rd_q    <= 1'b1;
      res_q   <= '0;
      s_st_q  <= 1'b0;
      s_in_q  <= '0;
    end else begin
      state_q <= state_d;
      stold_q <= ST;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      rd_q    <= rd_d;
      res_q   <= res_d;
      s_st_q  <= s_st_d;
      s_in_q  <= s_in_d;
    end
  end

  assign RD   = rd_q;
  assign RES  = res_q;
  assign S_ST = s_st_q;
  assign S_IN = s_in_q;

endmodule

// File: tb/tb_iteration_s_16.sv
// tb/tb_iteration_s_16.sv - scoreboard bench for iteration_s_16 with a variable-latency successor model
module tb_iteration_s_16;

  logic        CLK;
  logic        RST;
  logic        ST;
  logic        RD;
  logic [15:0] X;
  logic [15:0] N;
  logic [15:0] RES;
  logic        S_ST;
  logic [15:0] S_IN;
  logic        S_RD;
  logic [15:0] S_RES;

  typedef struct {
    logic [15:0] res;
    int          lat;
  } exp_t;

  exp_t        exp_q[$];
  logic [15:0] sin_q[$];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int lat    = 1;

  iteration_s_16 dut (
    .CLK  (CLK),
    .RST  (RST),
    .ST   (ST),
    .RD   (RD),
    .X    (X),
    .N    (N),
    .RES  (RES),
    .S_ST (S_ST),
    .S_IN (S_IN),
    .S_RD (S_RD),
    .S_RES(S_RES)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  // Successor stage model: RES = IN + 1 after 'lat' cycles of RD low.
  logic        c_old;
  logic [15:0] c_in;
  int          c_cnt;
  always @(posedge CLK or posedge RST) begin
    if (RST) begin
      S_RD  <= 1'b1;
      S_RES <= 16'h0;
      c_old <= 1'b0;
      c_in  <= 16'h0;
      c_cnt <= 0;
    end else begin
      c_old <= S_ST;
      if (S_RD && S_ST && !c_old) begin
        S_RD  <= 1'b0;
        c_in  <= S_IN;
        c_cnt <= lat - 1;
      end else if (!S_RD) begin
        if (c_cnt == 0) begin
          S_RD  <= 1'b1;
          S_RES <= c_in + 16'd1;
        end else begin
          c_cnt <= c_cnt - 1;
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Monitor: pops expectations on every S_ST rise and every RD rise.
  initial begin
    logic        prev_rd;
    logic        prev_sst;
    logic        had_fall;
    int          low_len;
    int          e0;
    logic [15:0] cur_sin;
    exp_t        e;
    prev_rd  = 1'b1;
    prev_sst = 1'b0;
    had_fall = 1'b0;
    low_len  = 0;
    e0       = 0;
    cur_sin  = 16'h0;
    forever begin
      @(negedge CLK);
      if (RST) begin
        prev_rd  = 1'b1;
        prev_sst = 1'b0;
        had_fall = 1'b0;
        low_len  = 0;
      end else begin
        if (prev_rd && !RD) begin
          e0       = cyc;
          had_fall = 1'b0;
        end
        if (!prev_sst && S_ST) begin
          if (sin_q.size() == 0) begin
            chk("unexpected_s_st", 32'(S_IN), 32'hFFFF_FFFF);
          end else begin
            chk("s_in", 32'(S_IN), 32'(sin_q.pop_front()));
          end
          if (had_fall) chk("gap_len", 32'(low_len), 32'd1);
          had_fall = 1'b0;
          cur_sin  = S_IN;
        end else if (prev_sst && S_ST) begin
          chk("s_in_stable", 32'(S_IN), 32'(cur_sin));
        end
        if (prev_sst && !S_ST && !RD) begin
          had_fall = 1'b1;
          low_len  = 0;
        end
        if (had_fall && !S_ST) low_len++;
        if (!prev_rd && RD) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_done", 32'(RES), 32'hFFFF_FFFF);
          end else begin
            e = exp_q.pop_front();
            chk("res", 32'(RES), 32'(e.res));
            chk("latency", 32'(cyc - e0), 32'(e.lat));
          end
        end
        prev_rd  = RD;
        prev_sst = S_ST;
      end
    end
  end

  task automatic wait_idle();
    int n;
    n = 0;
    while (!RD && n < 300) begin
      @(negedge CLK);
      n++;
    end
    if (!RD) chk("idle_timeout", 32'(RD), 32'd1);
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(negedge CLK);
      n++;
    end
    if (exp_q.size() != 0) begin
      chk("done_timeout", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
    end
  endtask

  task automatic run(input logic [15:0] x, input logic [15:0] n, input logic expect_done,
                     input logic [15:0] er, input int el, input int l);
    wait_idle();
    @(negedge CLK);
    lat = l;
    if (expect_done) exp_q.push_back('{res: er, lat: el});
    X  = x;
    N  = n;
    ST = 1'b1;
    @(negedge CLK);
    ST = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1);
  end

  initial begin
    RST = 1'b1;
    ST  = 1'b0;
    X   = 16'h0;
    N   = 16'h0;
    repeat (2) @(negedge CLK);
    chk("reset_rd", 32'(RD), 32'd1);
    chk("reset_res", 32'(RES), 32'd0);
    chk("reset_s_st", 32'(S_ST), 32'd0);
    chk("reset_s_in", 32'(S_IN), 32'd0);
    RST = 1'b0;
    repeat (2) @(negedge CLK);

    // X=5, N=3: three issues of 5,6,7 -> 8 after 11 cycles
    sin_q.push_back(16'd5);
    sin_q.push_back(16'd6);
    sin_q.push_back(16'd7);
    run(16'd5, 16'd3, 1'b1, 16'd8, 11, 1);
    wait_done();

    // N=0: no child traffic, result after one cycle
    run(16'h1234, 16'd0, 1'b1, 16'h1234, 1, 1);
    wait_done();

    // Wrap through 0xFFFF
    sin_q.push_back(16'hFFFE);
    sin_q.push_back(16'hFFFF);
    sin_q.push_back(16'h0000);
    run(16'hFFFE, 16'd3, 1'b1, 16'h0001, 11, 1);
    wait_done();

    // ST toggled twice while busy must be ignored
    for (int i = 0; i < 4; i++) sin_q.push_back(16'h0100 + 16'(i));
    run(16'h0100, 16'd4, 1'b1, 16'h0104, 15, 1);
    for (int i = 0; i < 2; i++) begin
      @(negedge CLK);
      ST = 1'b1;
      @(negedge CLK);
      ST = 1'b0;
    end
    wait_done();
    repeat (8) @(negedge CLK);
    chk("toggle_rd_hold", 32'(RD), 32'd1);
    chk("toggle_res_hold", 32'(RES), 32'h0104);

    // Reset while in WAIT_DONE of the first iteration of an N=5 run
    sin_q.push_back(16'd20);
    run(16'd20, 16'd5, 1'b0, 16'd0, 0, 1);
    @(posedge CLK);
    @(posedge CLK);
    #1;
    chk("pre_abort_busy", 32'(RD), 32'd0);
    RST = 1'b1;
    #1;
    chk("abort_rd", 32'(RD), 32'd1);
    chk("abort_res", 32'(RES), 32'd0);
    chk("abort_s_st", 32'(S_ST), 32'd0);
    @(negedge CLK);
    @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
    sin_q.push_back(16'd1);
    run(16'd1, 16'd1, 1'b1, 16'd2, 3, 1);
    wait_done();

    // Slow child (5-cycle latency): 2 iterations of 8 cycles minus the last gap
    sin_q.push_back(16'd10);
    sin_q.push_back(16'd11);
    run(16'd10, 16'd2, 1'b1, 16'd12, 15, 5);
    wait_done();
    repeat (4) @(negedge CLK);

    chk("exp_queue_empty", 32'(exp_q.size()), 32'd0);
    chk("sin_queue_empty", 32'(sin_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
